mem_copy_dma: RTL and testbench



---
 rtl/mem_copy_dma.sv | 137 +++++++++++++
 tb/tb_mem_copy_dma.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_dma.sv
// -----------------------------------------------------------------------------
// mem_copy_dma
//
// Block-copy bus initiator for a single-port synchronous RAM whose read data
// is registered (one-cycle latency). It copies Length bytes from SrcAddr to
// DstAddr one byte at a time, in ascending address order. Each byte takes
// three states: READ presents the source address, LATCH captures the RAM
// output, and WRITE drives the destination. Grant=0 stalls READ and WRITE so
// the arbiter can hand the bus to the CPU.
//
// Ports:
//   CLK         in   system clock, all state changes on posedge
//   RST         in   synchronous active-high reset
//   Start       in   copy request, sampled only while idle
//   SrcAddr     in   [15:0] first source address, sampled with Start
//   DstAddr     in   [15:0] first destination address, sampled with Start
//   Length      in   [15:0] byte count, 0 means no transfer
//   Grant       in   bus granted, 0 stalls READ and WRITE
//   Busy        out  high while a copy is in progress
//   Done        out  one-cycle pulse when a copy completes
//   MemWE       out  RAM write enable
//   MemAddress  out  [15:0] RAM address
//   MemDataOut  out  [7:0] RAM write data
//   MemDataIn   in   [7:0] RAM registered read data
// -----------------------------------------------------------------------------
module mem_copy_dma (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  input  logic [15:0] SrcAddr,
  input  logic [15:0] DstAddr,
  input  logic [15:0] Length,
  input  logic        Grant,
  output logic        Busy,
  output logic        Done,
  output logic        MemWE,
  output logic [15:0] MemAddress,
  output logic [7:0]  MemDataOut,
  input  logic [7:0]  MemDataIn
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_LATCH = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  state_e      state_q;
  logic [15:0] src_ptr_q;
  logic [15:0] dst_ptr_q;
  logic [15:0] remaining_q;
  logic [7:0]  data_q;
  logic        done_q;

  // Copy sequencer: state, pointers, byte counter, data latch and Done pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      src_ptr_q   <= 16'h0000;
      dst_ptr_q   <= 16'h0000;
      remaining_q <= 16'h0000;
      data_q      <= 8'h00;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            if (Length != 16'h0000) begin
              src_ptr_q   <= SrcAddr;
              dst_ptr_q   <= DstAddr;
              remaining_q <= Length;
              state_q     <= ST_READ;
            end else begin
              // Zero-length request completes immediately without using the bus.
              done_q <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (Grant) begin
            state_q <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          // RAM output now reflects the address presented in READ; capture
          // it unconditionally before the address moves to the destination.
          data_q  <= MemDataIn;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          if (Grant) begin
            // Pointers wrap modulo 2^16 by natural 16-bit overflow.
            src_ptr_q   <= src_ptr_q + 16'd1;
            dst_ptr_q   <= dst_ptr_q + 16'd1;
            remaining_q <= remaining_q - 16'd1;
            if (remaining_q == 16'd1) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus drive: write strobe only in WRITE with Grant, address follows state
  always_comb begin
    MemWE      = 1'b0;
    MemAddress = src_ptr_q;
    case (state_q)
      ST_WRITE: begin
        MemWE      = Grant;
        MemAddress = dst_ptr_q;
      end
      ST_IDLE, ST_READ, ST_LATCH: begin
        MemWE      = 1'b0;
        MemAddress = src_ptr_q;
      end
      default: begin
        MemWE      = 1'b0;
        MemAddress = src_ptr_q;
      end
    endcase
  end

  assign MemDataOut = data_q;
  assign Busy       = (state_q != ST_IDLE);
  assign Done       = done_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: byte-copy reference model feeds a
// write/done scoreboard; a negedge monitor pops and compares.
module tb_mem_copy_dma;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Start;
  logic [15:0] SrcAddr;
  logic [15:0] DstAddr;
  logic [15:0] Length;
  logic        Grant;
  logic        Busy;
  logic        Done;
  logic        MemWE;
  logic [15:0] MemAddress;
  logic [7:0]  MemDataOut;
  logic [7:0]  MemDataIn;

  always #5 CLK = ~CLK;

  mem_copy_dma dut (
    .CLK(CLK), .RST(RST), .Start(Start), .SrcAddr(SrcAddr), .DstAddr(DstAddr),
    .Length(Length), .Grant(Grant), .Busy(Busy), .Done(Done), .MemWE(MemWE),
    .MemAddress(MemAddress), .MemDataOut(MemDataOut), .MemDataIn(MemDataIn)
  );

  // RAM with registered read and a backdoor write port for preloading.
  logic [7:0]  ram [0:65535];
  logic [7:0]  rd_q;
  logic        bd_we;
  logic [15:0] bd_addr;
  logic [7:0]  bd_data;

  always @(posedge CLK) begin
    if (MemWE) ram[MemAddress] <= MemDataOut;
    else if (bd_we) ram[bd_addr] <= bd_data;
    rd_q <= ram[MemAddress];
  end
  assign MemDataIn = rd_q;

  // Reference memory: what the RAM should contain after each copy.
  logic [7:0] ref_mem [0:65535];

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t wq[$];
  int  dq[$];      // expected Done edge count, -1 = any time
  int  errors = 0;
  int  checks = 0;
  int  pos_count = 0;
  int  busy_seen = 0;
  int  wr_seen = 0;
  wr_t mon_e;
  int  mon_d;

  always @(posedge CLK) pos_count++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pop expected writes and Done pulses as the DUT presents them.
  always @(negedge CLK) begin
    if (Busy) busy_seen++;
    if (MemWE) begin
      wr_seen++;
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required none", MemAddress, MemDataOut);
      end else begin
        mon_e = wq.pop_front();
        chk("wr_addr", {16'h0, MemAddress}, {16'h0, mon_e.a});
        chk("wr_data", {24'h0, MemDataOut}, {24'h0, mon_e.d});
      end
    end
    if (Done) begin
      chk("done_busy", {31'h0, Busy}, 32'h0);
      if (dq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got Done=1 at edge %0d, required none", pos_count);
      end else begin
        mon_d = dq.pop_front();
        if (mon_d >= 0) chk("done_cycle", pos_count, mon_d);
      end
    end
  end

  task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge CLK); #1;
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // Issue Start; model the first nb bytes of the copy. Returns edge count of e0.
  task automatic start_copy(input logic [15:0] src, input logic [15:0] dst,
                            input logic [15:0] len, input int nb,
                            input bit exp_done, input int stall, input bit any_time,
                            output int p0);
    logic [15:0] sa;
    logic [15:0] da;
    wr_t w;
    for (int i = 0; i < nb; i++) begin
      sa = src + 16'(i);
      da = dst + 16'(i);
      ref_mem[da] = ref_mem[sa];
      w.a = da;
      w.d = ref_mem[da];
      wq.push_back(w);
    end
    Start = 1'b1; SrcAddr = src; DstAddr = dst; Length = len;
    @(posedge CLK); #1;
    p0 = pos_count;
    Start = 1'b0;
    if (exp_done) dq.push_back(any_time ? -1 : p0 + 3 * int'(len) + stall);
  endtask

  task automatic wait_idle(input bit rand_grant);
    int n;
    n = 0;
    while ((wq.size() != 0 || dq.size() != 0) && n < 1000) begin
      if (rand_grant) Grant = ($urandom_range(0, 3) != 0);
      @(posedge CLK); #1;
      n++;
    end
    Grant = 1'b1;
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL timeout: got %0d pending writes %0d pending done, required 0", wq.size(), dq.size());
      wq.delete(); dq.delete();
    end
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  {31'h0, Busy},  32'h0);
    chk({tag, "_done"},  {31'h0, Done},  32'h0);
    chk({tag, "_we"},    {31'h0, MemWE}, 32'h0);
    chk({tag, "_addr"},  {16'h0, MemAddress}, 32'h0);
    chk({tag, "_wdata"}, {24'h0, MemDataOut}, 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int p0;
    int b0;
    int w0;
    logic [15:0] rs, rdst, rl;
    bit rg;

    RST = 1'b1; Start = 1'b0; Grant = 1'b1;
    SrcAddr = 16'h0; DstAddr = 16'h0; Length = 16'h0;
    bd_we = 1'b0; bd_addr = 16'h0; bd_data = 8'h0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_outputs("reset");
    RST = 1'b0;
    @(posedge CLK); #1;

    // Basic 4-byte copy, with a Start pulse issued while busy that must be ignored.
    bd_write(16'h0010, 8'hAA); bd_write(16'h0011, 8'hBB);
    bd_write(16'h0012, 8'hCC); bd_write(16'h0013, 8'hDD);
    w0 = wr_seen;
    start_copy(16'h0010, 16'h0100, 16'd4, 4, 1'b1, 0, 1'b0, p0);
    @(posedge CLK); #1;
    Start = 1'b1; SrcAddr = 16'h5555; DstAddr = 16'h6666; Length = 16'd7;
    @(posedge CLK); #1;
    Start = 1'b0;
    wait_idle(1'b0);
    chk("t1_ram0", {24'h0, ram[16'h0100]}, 32'hAA);
    chk("t1_ram1", {24'h0, ram[16'h0101]}, 32'hBB);
    chk("t1_ram2", {24'h0, ram[16'h0102]}, 32'hCC);
    chk("t1_ram3", {24'h0, ram[16'h0103]}, 32'hDD);
    chk("t1_we_cycles", wr_seen - w0, 32'd4);

    // Zero length: Done in cycle 1, never busy, never writes.
    b0 = busy_seen; w0 = wr_seen;
    start_copy(16'h0040, 16'h0050, 16'd0, 0, 1'b1, 0, 1'b0, p0);
    wait_idle(1'b0);
    chk("t2_busy", busy_seen - b0, 32'd0);
    chk("t2_we", wr_seen - w0, 32'd0);

    // Source pointer wraps FFFF -> 0000.
    bd_write(16'hFFFE, 8'h5A); bd_write(16'hFFFF, 8'hA5); bd_write(16'h0000, 8'h3C);
    start_copy(16'hFFFE, 16'h0200, 16'd3, 3, 1'b1, 0, 1'b0, p0);
    wait_idle(1'b0);
    chk("t3_ram0", {24'h0, ram[16'h0200]}, 32'h5A);
    chk("t3_ram1", {24'h0, ram[16'h0201]}, 32'hA5);
    chk("t3_ram2", {24'h0, ram[16'h0202]}, 32'h3C);

    // Five-cycle Grant stall during the second byte's WRITE (cycles 6..10).
    for (int i = 0; i < 4; i++) bd_write(16'h0300 + 16'(i), 8'($urandom));
    start_copy(16'h0300, 16'h0400, 16'd4, 4, 1'b1, 5, 1'b0, p0);
    repeat (5) @(posedge CLK);
    #1;
    Grant = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("t4_stall_we", {31'h0, MemWE}, 32'h0);
      chk("t4_stall_addr", {16'h0, MemAddress}, 32'h0401);
      @(posedge CLK);
    end
    #1;
    Grant = 1'b1;
    wait_idle(1'b0);

    // Overlapping forward copy replicates the first byte.
    bd_write(16'h0020, 8'h11); bd_write(16'h0021, 8'h99);
    bd_write(16'h0022, 8'h98); bd_write(16'h0023, 8'h97);
    start_copy(16'h0020, 16'h0021, 16'd3, 3, 1'b1, 0, 1'b0, p0);
    wait_idle(1'b0);
    chk("t5_ram1", {24'h0, ram[16'h0021]}, 32'h11);
    chk("t5_ram2", {24'h0, ram[16'h0022]}, 32'h11);
    chk("t5_ram3", {24'h0, ram[16'h0023]}, 32'h11);

    // Reset during byte 2 LATCH (cycle 8): only bytes 0,1 written, no Done.
    for (int i = 0; i < 4; i++) bd_write(16'h0500 + 16'(i), 8'($urandom));
    bd_write(16'h0602, 8'h77); bd_write(16'h0603, 8'h66);
    start_copy(16'h0500, 16'h0600, 16'd4, 2, 1'b0, 0, 1'b0, p0);
    repeat (7) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    chk_reset_outputs("midreset");
    RST = 1'b0;
    chk("t6_pending_writes", wq.size(), 32'd0);
    wait_idle(1'b0);
    chk("t6_ram2_untouched", {24'h0, ram[16'h0602]}, 32'h77);
    chk("t6_ram3_untouched", {24'h0, ram[16'h0603]}, 32'h66);
    start_copy(16'h0500, 16'h0600, 16'd4, 4, 1'b1, 0, 1'b0, p0);
    wait_idle(1'b0);

    // Randomized copies, half of them with random Grant stalls.
    for (int t = 0; t < 12; t++) begin
      rs   = 16'($urandom);
      rdst = 16'($urandom_range(0, 1) != 0 ? rs + 16'($urandom_range(0, 4)) : 16'($urandom));
      rl   = 16'($urandom_range(1, 7));
      rg   = t[0];
      for (int i = 0; i < int'(rl); i++) bd_write(rs + 16'(i), 8'($urandom));
      start_copy(rs, rdst, rl, int'(rl), 1'b1, 0, rg, p0);
      wait_idle(rg);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
